beat_sequencer: RTL and testbench

- Generates the machine-cycle beat signals w1/w2/w3 that drive the hardwired instruction controller.
- Honours the controller's short/long/stop requests and the front-panel start key qd.
- Supports single-step mode.
- Synchronises the external interrupt pulse into a level request held until the controller acknowledges it.
- Sits between the panel/clock logic and the controller; owns all cycle sequencing.

---
 rtl/beat_sequencer.sv | 112 +++++++++++
 tb/tb_beat_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// Machine-cycle beat generator (w1/w2/w3) for the hardwired controller, with
// start-key and interrupt synchronisers and a completed-cycle counter.
module beat_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             step_mode,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    input  logic             pulse,
    input  logic             int_ack,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic             int_req,
    output logic [CNT_W-1:0] cyc_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, W1 = 2'd1, W2 = 2'd2, W3 = 2'd3} state_t;

    state_t state, state_nx;
    logic   qd_s1, qd_s2, qd_prev, qd_rise;
    logic   pl_s1, pl_s2, pl_prev, pl_rise;
    logic   stop_pend, cyc_end;
    logic   w1_nx, w2_nx, w3_nx, running_nx;

    // Two-flop synchronisers followed by an edge register for both async inputs.
    always_ff @(posedge t3) begin
        if (!clr) begin
            {qd_s1, qd_s2, qd_prev} <= 3'b000;
            {pl_s1, pl_s2, pl_prev} <= 3'b000;
        end else begin
            qd_s1   <= qd;
            qd_s2   <= qd_s1;
            qd_prev <= qd_s2;
            pl_s1   <= pulse;
            pl_s2   <= pl_s1;
            pl_prev <= pl_s2;
        end
    end

    assign qd_rise = qd_s2 & ~qd_prev;
    assign pl_rise = pl_s2 & ~pl_prev;

    // State register; beat outputs are registered alongside it.
    always_ff @(posedge t3) begin
        if (!clr) begin
            state   <= IDLE;
            w1      <= 1'b0;
            w2      <= 1'b0;
            w3      <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            w1      <= w1_nx;
            w2      <= w2_nx;
            w3      <= w3_nx;
            running <= running_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cyc_end  = 1'b0;
        case (state)
            IDLE: if (qd_rise) state_nx = W1;
            W1:   if (short) cyc_end = 1'b1; else state_nx = W2;
            W2:   if (long) state_nx = W3; else cyc_end = 1'b1;
            W3:   cyc_end = 1'b1;
            default: state_nx = IDLE;
        endcase
        if (cyc_end)
            state_nx = (stop || stop_pend || step_mode) ? IDLE : W1;
    end

    always_comb begin
        w1_nx      = (state_nx == W1);
        w2_nx      = (state_nx == W2);
        w3_nx      = (state_nx == W3);
        running_nx = (state_nx != IDLE);
    end

    // A stop raised mid-cycle is remembered so the halt lands on the cycle boundary.
    always_ff @(posedge t3) begin
        if (!clr) begin
            cyc_cnt   <= '0;
            stop_pend <= 1'b0;
        end else begin
            if (cyc_end)
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (cyc_end)
                stop_pend <= 1'b0;
            else if (stop && state != IDLE)
                stop_pend <= 1'b1;
        end
    end

    // A new edge outranks a simultaneous acknowledge.
    always_ff @(posedge t3) begin
        if (!clr)
            int_req <= 1'b0;
        else if (pl_rise)
            int_req <= 1'b1;
        else if (int_ack)
            int_req <= 1'b0;
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: directed scenarios plus random
// stimulus against an input-history based reference model.
module tb_beat_sequencer;

    logic        t3 = 1'b0;
    logic        clr = 1'b0, qd = 1'b0, step_mode = 1'b0;
    logic        short = 1'b0, long = 1'b0, stop = 1'b0;
    logic        pulse = 1'b0, int_ack = 1'b0;
    logic        w1, w2, w3, running, int_req;
    logic [15:0] cyc_cnt;

    int total = 0;
    int bad   = 0;

    beat_sequencer #(.CNT_W(16)) dut (
        .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode),
        .short(short), .long(long), .stop(stop),
        .pulse(pulse), .int_ack(int_ack),
        .w1(w1), .w2(w2), .w3(w3), .running(running),
        .int_req(int_req), .cyc_cnt(cyc_cnt)
    );

    always #5 t3 = ~t3;

    // Reference model: beat number 0 = idle, 1..3 = position inside the cycle.
    // Async inputs are kept as sample histories; bit k = value seen k+1 edges ago.
    int          m_beat = 0;
    logic [15:0] m_cnt  = 16'd0;
    logic        m_halt = 1'b0;
    logic        m_int  = 1'b0;
    logic [2:0]  qh = 3'b000, ph = 3'b000;

    always @(posedge t3) begin
        logic start, irq_edge, last_beat;
        if (!clr) begin
            m_beat = 0; m_cnt = 16'd0; m_halt = 1'b0; m_int = 1'b0;
            qh = 3'b000; ph = 3'b000;
        end else begin
            start    = qh[1] && !qh[2];
            irq_edge = ph[1] && !ph[2];
            last_beat = (m_beat == 1 && short) || (m_beat == 2 && !long) || (m_beat == 3);
            if (m_beat == 0) begin
                if (start) m_beat = 1;
            end else if (last_beat) begin
                m_cnt  = m_cnt + 16'd1;
                m_beat = (stop || m_halt || step_mode) ? 0 : 1;
                m_halt = 1'b0;
            end else begin
                if (stop) m_halt = 1'b1;
                m_beat = m_beat + 1;
            end
            if (irq_edge)     m_int = 1'b1;
            else if (int_ack) m_int = 1'b0;
            qh = {qh[1:0], qd};
            ph = {ph[1:0], pulse};
        end
    end

    function automatic logic [20:0] exp_vec();
        return {m_beat == 1, m_beat == 2, m_beat == 3, m_beat != 0, m_int, m_cnt};
    endfunction

    wire [20:0] obs_vec = {w1, w2, w3, running, int_req, cyc_cnt};

    task automatic test_reset();
        clr = 1'b0;
        repeat (2) @(posedge t3);
        @(negedge t3);
        total++;
        if (obs_vec !== 21'd0) $display("FAIL reset_state got=%h exp=%h", obs_vec, 21'd0);
        if (obs_vec !== 21'd0) bad++;
        clr = 1'b1;
        repeat (4) begin
            @(negedge t3);
            total++;
            if (obs_vec !== 21'd0) begin
                $display("FAIL reset_idle got=%h exp=%h", obs_vec, 21'd0);
                bad++;
            end
        end
    endtask

    task automatic test_normal();
        int guard = 0;
        qd = 1'b1;
        while (m_beat != 1 && guard < 10) begin
            @(negedge t3);
            guard++;
        end
        total++;
        if (m_beat != 1 || w1 !== 1'b1) begin
            $display("FAIL normal_start got_w1=%b guard=%0d exp_w1=1", w1, guard);
            bad++;
        end
        repeat (8) begin
            @(negedge t3);
            total++;
            if (obs_vec !== exp_vec()) begin
                $display("FAIL normal_seq got=%h exp=%h", obs_vec, exp_vec());
                bad++;
            end
        end
        total++;
        if (cyc_cnt !== 16'd4 || w1 !== 1'b1) begin
            $display("FAIL normal_count got_cnt=%0d got_w1=%b exp_cnt=4 exp_w1=1", cyc_cnt, w1);
            bad++;
        end
    endtask

    task automatic test_long();
        int n_w3 = 0;
        repeat (12) begin
            long = (m_beat == 2);
            @(negedge t3);
            if (w3) n_w3++;
            total++;
            if (obs_vec !== exp_vec()) begin
                $display("FAIL long_seq got=%h exp=%h", obs_vec, exp_vec());
                bad++;
            end
        end
        long = 1'b0;
        total++;
        if (n_w3 != 4 || cyc_cnt !== 16'd8) begin
            $display("FAIL long_count got_w3=%0d got_cnt=%0d exp_w3=4 exp_cnt=8", n_w3, cyc_cnt);
            bad++;
        end
    endtask

    task automatic test_short();
        int n_w2 = 0;
        short = 1'b1; long = 1'b1;
        repeat (6) begin
            @(negedge t3);
            if (w2) n_w2++;
            total++;
            if (obs_vec !== exp_vec()) begin
                $display("FAIL short_seq got=%h exp=%h", obs_vec, exp_vec());
                bad++;
            end
        end
        short = 1'b0; long = 1'b0;
        total++;
        if (n_w2 != 0 || cyc_cnt !== 16'd14) begin
            $display("FAIL short_count got_w2=%0d got_cnt=%0d exp_w2=0 exp_cnt=14", n_w2, cyc_cnt);
            bad++;
        end
    endtask

    task automatic test_stop();
        int n_w3 = 0;
        for (int i = 0; i < 8; i++) begin
            stop = (i == 0);
            long = (m_beat == 2);
            @(negedge t3);
            if (w3) n_w3++;
            total++;
            if (obs_vec !== exp_vec()) begin
                $display("FAIL stop_seq got=%h exp=%h", obs_vec, exp_vec());
                bad++;
            end
        end
        stop = 1'b0; long = 1'b0;
        total++;
        if (running !== 1'b0 || cyc_cnt !== 16'd15 || n_w3 != 1) begin
            $display("FAIL stop_halt got_run=%b got_cnt=%0d got_w3=%0d exp_run=0 exp_cnt=15 exp_w3=1",
                     running, cyc_cnt, n_w3);
            bad++;
        end
        qd = 1'b0;
        repeat (4) @(negedge t3);
        qd = 1'b1;
        @(negedge t3);
        @(negedge t3);
        total++;
        if (w1 !== 1'b0) begin
            $display("FAIL restart_early got_w1=%b exp_w1=0", w1);
            bad++;
        end
        @(negedge t3);
        total++;
        if (w1 !== 1'b1) begin
            $display("FAIL restart got_w1=%b exp_w1=1", w1);
            bad++;
        end
    endtask

    task automatic test_step();
        logic [15:0] c0;
        step_mode = 1'b1;
        repeat (4) @(negedge t3);
        c0 = m_cnt;
        repeat (3) begin
            qd = 1'b0;
            repeat (3) @(negedge t3);
            qd = 1'b1;
            repeat (6) begin
                @(negedge t3);
                total++;
                if (obs_vec !== exp_vec()) begin
                    $display("FAIL step_seq got=%h exp=%h", obs_vec, exp_vec());
                    bad++;
                end
            end
        end
        total++;
        if (cyc_cnt !== c0 + 16'd3 || running !== 1'b0) begin
            $display("FAIL step_count got_cnt=%0d got_run=%b exp_cnt=%0d exp_run=0",
                     cyc_cnt, running, c0 + 16'd3);
            bad++;
        end
        step_mode = 1'b0;
    endtask

    task automatic test_wrap();
        int guard = 0;
        clr = 1'b0; qd = 1'b0;
        @(negedge t3);
        clr = 1'b1; qd = 1'b1; short = 1'b1;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            @(negedge t3);
            guard++;
        end
        total++;
        if (cyc_cnt !== 16'hFFFF) begin
            $display("FAIL wrap_preload got=%h exp=ffff guard=%0d", cyc_cnt, guard);
            bad++;
        end
        @(negedge t3);
        total++;
        if (cyc_cnt !== 16'h0000 || w1 !== 1'b1) begin
            $display("FAIL wrap_zero got_cnt=%h got_w1=%b exp_cnt=0000 exp_w1=1", cyc_cnt, w1);
            bad++;
        end
        short = 1'b0;
    endtask

    task automatic test_interrupt();
        step_mode = 1'b1; qd = 1'b0;
        repeat (4) @(negedge t3);
        pulse = 1'b1;
        @(negedge t3);
        pulse = 1'b0;
        total++;
        if (int_req !== 1'b0) begin $display("FAIL irq_e1 got=%b exp=0", int_req); bad++; end
        @(negedge t3);
        total++;
        if (int_req !== 1'b0) begin $display("FAIL irq_e2 got=%b exp=0", int_req); bad++; end
        @(negedge t3);
        total++;
        if (int_req !== 1'b1) begin $display("FAIL irq_e3 got=%b exp=1", int_req); bad++; end
        repeat (3) @(negedge t3);
        total++;
        if (int_req !== 1'b1) begin $display("FAIL irq_hold got=%b exp=1", int_req); bad++; end
        // second edge lands on the same edge as the acknowledge
        pulse = 1'b1;
        @(negedge t3);
        pulse = 1'b0;
        @(negedge t3);
        int_ack = 1'b1;
        @(negedge t3);
        int_ack = 1'b0;
        total++;
        if (int_req !== 1'b1) begin $display("FAIL irq_ack_collide got=%b exp=1", int_req); bad++; end
        int_ack = 1'b1;
        @(negedge t3);
        int_ack = 1'b0;
        total++;
        if (int_req !== 1'b0) begin $display("FAIL irq_ack got=%b exp=0", int_req); bad++; end
        pulse = 1'b1;
        repeat (4) @(negedge t3);
        total++;
        if (int_req !== 1'b1) begin $display("FAIL irq_level got=%b exp=1", int_req); bad++; end
        int_ack = 1'b1;
        @(negedge t3);
        int_ack = 1'b0;
        repeat (3) @(negedge t3);
        total++;
        if (int_req !== 1'b0) begin $display("FAIL irq_level_once got=%b exp=0", int_req); bad++; end
        pulse = 1'b0;
        step_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        qd = 1'b1;
        while (m_beat != 2 && guard < 20) begin
            @(negedge t3);
            guard++;
        end
        total++;
        if (w2 !== 1'b1) begin $display("FAIL mid_reach got_w2=%b exp_w2=1", w2); bad++; end
        clr = 1'b0;
        @(negedge t3);
        total++;
        if (obs_vec !== 21'd0) begin
            $display("FAIL mid_reset got=%h exp=%h", obs_vec, 21'd0);
            bad++;
        end
        clr = 1'b1; qd = 1'b0;
    endtask

    task automatic test_random();
        repeat (600) begin
            if ($urandom_range(0, 7) == 0) qd = ~qd;
            if ($urandom_range(0, 31) == 0) step_mode = ~step_mode;
            short   = ($urandom_range(0, 3) == 0);
            long    = ($urandom_range(0, 1) == 0);
            stop    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) pulse = ~pulse;
            int_ack = ($urandom_range(0, 9) == 0);
            clr     = ($urandom_range(0, 149) != 0);
            @(negedge t3);
            total++;
            if (obs_vec !== exp_vec()) begin
                $display("FAIL random got=%h exp=%h", obs_vec, exp_vec());
                bad++;
            end
        end
        clr = 1'b1;
    endtask

    initial begin
        @(negedge t3);
        test_reset();
        test_normal();
        test_long();
        test_short();
        test_stop();
        test_step();
        test_wrap();
        test_interrupt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
